// File: rtl/gerenciador_atributos_pkg.sv
// Shared definitions for the pet attribute manager: the one-hot estado
// encoding driven by controlador_estados, the decoded activity type and the
// default tuning constants.
package gerenciador_atributos_pkg;

  // One-hot estado encoding shared with controlador_estados (INTRO is all-zero).
  localparam logic [4:0] INTRO      = 5'b00000;
  localparam logic [4:0] IDLE       = 5'b00001;
  localparam logic [4:0] DORMINDO   = 5'b00010;
  localparam logic [4:0] COMENDO    = 5'b00100;
  localparam logic [4:0] DANDO_AULA = 5'b01000;
  localparam logic [4:0] MORTO      = 5'b10000;

  // Default tuning constants.
  localparam int         DEF_TICK_BITS   = 22;
  localparam logic [7:0] DEF_INIT_VALUE  = 8'd200;
  localparam logic [7:0] DEF_GAIN        = 8'd8;
  localparam logic [7:0] DEF_DECAY       = 8'd1;
  localparam logic [7:0] DEF_ALERT_LEVEL = 8'd32;

  // Decoded activity; anything that is not a legal one-hot code maps to ACT_INVALID.
  typedef enum logic [2:0] {
    ACT_INTRO      = 3'd0,
    ACT_IDLE       = 3'd1,
    ACT_DORMINDO   = 3'd2,
    ACT_COMENDO    = 3'd3,
    ACT_DANDO_AULA = 3'd4,
    ACT_MORTO      = 3'd5,
    ACT_INVALID    = 3'd6
  } atividade_t;

  // Per-attribute update request issued by the top level to atributo_sat.
  typedef struct packed {
    logic       inc_en;
    logic       dec_en;
    logic [7:0] dec_amt;
  } atributo_ctrl_t;

  function automatic atividade_t decode_estado(input logic [4:0] estado);
    atividade_t atividade;
    case (estado)
      INTRO:      atividade = ACT_INTRO;
      IDLE:       atividade = ACT_IDLE;
      DORMINDO:   atividade = ACT_DORMINDO;
      COMENDO:    atividade = ACT_COMENDO;
      DANDO_AULA: atividade = ACT_DANDO_AULA;
      MORTO:      atividade = ACT_MORTO;
      default:    atividade = ACT_INVALID;
    endcase
    return atividade;
  endfunction

  // Doubles a decay amount, capping at 255 instead of wrapping.
  function automatic logic [7:0] dobro_sat(input logic [7:0] valor);
    logic [8:0] dobro;
    dobro = {valor, 1'b0};
    return dobro[8] ? 8'hFF : dobro[7:0];
  endfunction

endpackage

// File: rtl/gerenciador_atributos_atributo_sat.sv
// One saturating 8-bit attribute register. Priority: rst, then load, then
// the combined increment/decrement. Increment and decrement requested in the
// same cycle are both applied and only the net result is saturated to [0,255].
module atributo_sat
  import gerenciador_atributos_pkg::*;
#(
  parameter logic [7:0] RESET_VALUE = DEF_INIT_VALUE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       inc_en,
  input  logic       dec_en,
  input  logic [7:0] inc_amt,
  input  logic [7:0] dec_amt,
  output logic [7:0] valor
);

  logic [8:0] soma;
  logic [8:0] subtraendo;
  logic [8:0] diferenca;
  logic [7:0] proximo;

  // Net update in 9 bits: add first, then floor at 0 and cap at 255.
  always_comb begin
    soma       = {1'b0, valor} + (inc_en ? {1'b0, inc_amt} : 9'd0);
    subtraendo = dec_en ? {1'b0, dec_amt} : 9'd0;
    diferenca  = 9'd0;
    proximo    = valor;
    if (soma < subtraendo) begin
      proximo = 8'd0;
    end else begin
      diferenca = soma - subtraendo;
      proximo   = diferenca[8] ? 8'hFF : diferenca[7:0];
    end
  end

  // Attribute register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valor <= RESET_VALUE;
    end else if (load) begin
      valor <= load_value;
    end else if (inc_en || dec_en) begin
      valor <= proximo;
    end
  end

endmodule

// File: rtl/gerenciador_atributos.sv
// Pet attribute manager. A free-running prescaler produces a tick every
// 2**TICK_BITS cycles; on each tick the attributes decay on a 4-phase
// schedule and the one matching the current activity is replenished.
// estado is only looked at in tick cycles, except INTRO which reloads the
// attributes and holds the prescaler every cycle it is present.
module gerenciador_atributos
  import gerenciador_atributos_pkg::*;
#(
  parameter int         TICK_BITS   = DEF_TICK_BITS,
  parameter logic [7:0] INIT_VALUE  = DEF_INIT_VALUE,
  parameter logic [7:0] GAIN        = DEF_GAIN,
  parameter logic [7:0] DECAY       = DEF_DECAY,
  parameter logic [7:0] ALERT_LEVEL = DEF_ALERT_LEVEL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] estado,
  output logic [7:0] fome,
  output logic [7:0] felicidade,
  output logic [7:0] sono,
  output logic       tick,
  output logic       alerta
);

  localparam logic [7:0] DECAY2 = dobro_sat(DECAY);

  logic [TICK_BITS-1:0] prescaler;
  logic [1:0]           phase;
  logic                 tick_r;
  logic                 alerta_r;

  atividade_t     atividade;
  logic           intro;
  logic           sched_sono;
  logic           sched_felicidade;
  atributo_ctrl_t ctrl_fome;
  atributo_ctrl_t ctrl_felicidade;
  atributo_ctrl_t ctrl_sono;

  assign atividade        = decode_estado(estado);
  assign intro            = (atividade == ACT_INTRO);
  assign sched_sono       = phase[0];
  assign sched_felicidade = (phase == 2'b11);

  // Prescaler and phase counter; tick is registered so it is high in the
  // cycle the count sits at 0 right after wrapping. INTRO pins everything at 0.
  always_ff @(posedge clk) begin
    if (rst || intro) begin
      prescaler <= '0;
      phase     <= 2'd0;
      tick_r    <= 1'b0;
    end else begin
      prescaler <= prescaler + TICK_BITS'(1);
      tick_r    <= (prescaler == '1);
      if (tick_r) begin
        phase <= phase + 2'd1;
      end
    end
  end

  // alerta reflects the registered attributes one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      alerta_r <= 1'b0;
    end else begin
      alerta_r <= (fome < ALERT_LEVEL) || (felicidade < ALERT_LEVEL) ||
                  (sono < ALERT_LEVEL);
    end
  end

  // Per-tick update requests: scheduled decay for every attribute except the
  // one being replenished; MORTO and invalid codes request nothing.
  always_comb begin
    ctrl_fome       = '{inc_en: 1'b0, dec_en: 1'b0, dec_amt: DECAY};
    ctrl_felicidade = '{inc_en: 1'b0, dec_en: 1'b0, dec_amt: DECAY};
    ctrl_sono       = '{inc_en: 1'b0, dec_en: 1'b0, dec_amt: DECAY};
    if (tick_r) begin
      case (atividade)
        ACT_IDLE: begin
          ctrl_fome.dec_en       = 1'b1;
          ctrl_sono.dec_en       = sched_sono;
          ctrl_felicidade.dec_en = sched_felicidade;
        end
        ACT_COMENDO: begin
          ctrl_fome.inc_en       = 1'b1;
          ctrl_sono.dec_en       = sched_sono;
          ctrl_felicidade.dec_en = sched_felicidade;
        end
        ACT_DORMINDO: begin
          ctrl_sono.inc_en       = 1'b1;
          ctrl_fome.dec_en       = 1'b1;
          ctrl_felicidade.dec_en = sched_felicidade;
        end
        ACT_DANDO_AULA: begin
          ctrl_felicidade.inc_en = 1'b1;
          ctrl_fome.dec_en       = 1'b1;
          ctrl_fome.dec_amt      = DECAY2;
          ctrl_sono.dec_en       = sched_sono;
          ctrl_sono.dec_amt      = DECAY2;
        end
        default: begin
        end
      endcase
    end
  end

  atributo_sat #(.RESET_VALUE(INIT_VALUE)) u_fome (
    .clk        (clk),
    .rst        (rst),
    .load       (intro),
    .load_value (INIT_VALUE),
    .inc_en     (ctrl_fome.inc_en),
    .dec_en     (ctrl_fome.dec_en),
    .inc_amt    (GAIN),
    .dec_amt    (ctrl_fome.dec_amt),
    .valor      (fome)
  );

  atributo_sat #(.RESET_VALUE(INIT_VALUE)) u_felicidade (
    .clk        (clk),
    .rst        (rst),
    .load       (intro),
    .load_value (INIT_VALUE),
    .inc_en     (ctrl_felicidade.inc_en),
    .dec_en     (ctrl_felicidade.dec_en),
    .inc_amt    (GAIN),
    .dec_amt    (ctrl_felicidade.dec_amt),
    .valor      (felicidade)
  );

  atributo_sat #(.RESET_VALUE(INIT_VALUE)) u_sono (
    .clk        (clk),
    .rst        (rst),
    .load       (intro),
    .load_value (INIT_VALUE),
    .inc_en     (ctrl_sono.inc_en),
    .dec_en     (ctrl_sono.dec_en),
    .inc_amt    (GAIN),
    .dec_amt    (ctrl_sono.dec_amt),
    .valor      (sono)
  );

  assign tick   = tick_r;
  assign alerta = alerta_r;

endmodule

// File: tb/tb_gerenciador_atributos.sv
// Bench for gerenciador_atributos with TICK_BITS=4 (one tick per 16 cycles).
// Reference model: ticks happen every 16th cycle since the last reset/INTRO,
// the decay phase is the tick count modulo 4, and attribute updates are plain
// integer arithmetic clamped to [0,255].
module tb_gerenciador_atributos;
  import gerenciador_atributos_pkg::*;

  localparam int PERIOD = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] estado;
  logic [7:0] fome;
  logic [7:0] felicidade;
  logic [7:0] sono;
  logic       tick;
  logic       alerta;

  always #5 clk = ~clk;

  gerenciador_atributos #(.TICK_BITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .estado     (estado),
    .fome       (fome),
    .felicidade (felicidade),
    .sono       (sono),
    .tick       (tick),
    .alerta     (alerta)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [25:0] exp_q[$];   // {fome, felicidade, sono, tick, alerta}

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_fome, m_fel, m_sono;
  int m_since;       // cycles since the prescaler was last cleared
  int m_ticks;       // ticks since the last clear
  bit m_tick;
  bit m_alerta;

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic apply_tick(input logic [4:0] e, input int ph);
    int d_sono, d_fel;
    d_sono = (ph % 2 == 1) ? 1 : 0;
    d_fel  = (ph == 3) ? 1 : 0;
    case (e)
      IDLE: begin
        m_fome = clamp(m_fome - 1);
        m_sono = clamp(m_sono - d_sono);
        m_fel  = clamp(m_fel - d_fel);
      end
      COMENDO: begin
        m_fome = clamp(m_fome + 8);
        m_sono = clamp(m_sono - d_sono);
        m_fel  = clamp(m_fel - d_fel);
      end
      DORMINDO: begin
        m_sono = clamp(m_sono + 8);
        m_fome = clamp(m_fome - 1);
        m_fel  = clamp(m_fel - d_fel);
      end
      DANDO_AULA: begin
        m_fel  = clamp(m_fel + 8);
        m_fome = clamp(m_fome - 2);
        m_sono = clamp(m_sono - 2 * d_sono);
      end
      default: begin
      end
    endcase
  endtask

  task automatic model_step(input bit r, input logic [4:0] e);
    if (r) begin
      m_fome = 200; m_fel = 200; m_sono = 200;
      m_since = 0; m_ticks = 0; m_tick = 0; m_alerta = 0;
    end else begin
      m_alerta = (m_fome < 32) || (m_fel < 32) || (m_sono < 32);
      if (e == INTRO) begin
        m_fome = 200; m_fel = 200; m_sono = 200;
        m_since = 0; m_ticks = 0; m_tick = 0;
      end else begin
        if (m_tick) begin
          apply_tick(e, m_ticks % 4);
          m_ticks++;
        end
        m_since++;
        m_tick = (m_since % PERIOD == 0);
      end
    end
    exp_q.push_back({m_fome[7:0], m_fel[7:0], m_sono[7:0], m_tick, m_alerta});
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drive, let one posedge happen, check at the next negedge.
  task automatic cycle(input bit r, input logic [4:0] e);
    logic [25:0] ex;
    rst    = r;
    estado = e;
    @(posedge clk);
    model_step(r, e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      ex = exp_q.pop_front();
      check("fome",       int'(fome),       int'(ex[25:18]));
      check("felicidade", int'(felicidade), int'(ex[17:10]));
      check("sono",       int'(sono),       int'(ex[9:2]));
      check("tick",       int'(tick),       int'(ex[1]));
      check("alerta",     int'(alerta),     int'(ex[0]));
    end
  endtask

  // Runs estado until the DUT pulses tick; returns cycles taken (bounded).
  task automatic run_until_tick(input logic [4:0] e, output int n);
    bit got;
    n = 0;
    got = 0;
    while (n < 3 * PERIOD && !got) begin
      cycle(1'b0, e);
      n++;
      if (tick) got = 1;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [4:0] pool [8];

  initial begin
    int n;
    bit seen_low;
    int snap_f, snap_h, snap_s;
    logic [4:0] e;
    int hold;

    pool[0] = INTRO;    pool[1] = IDLE;       pool[2] = DORMINDO;
    pool[3] = COMENDO;  pool[4] = DANDO_AULA; pool[5] = MORTO;
    pool[6] = 5'b00011; pool[7] = 5'b11111;

    rst = 1'b1;
    estado = IDLE;
    @(negedge clk);

    // Reset state
    cycle(1'b1, IDLE);
    check("rst_fome", int'(fome), 200);
    check("rst_felicidade", int'(felicidade), 200);
    check("rst_sono", int'(sono), 200);
    check("rst_tick", int'(tick), 0);
    check("rst_alerta", int'(alerta), 0);

    // First tick 16 cycles after reset release
    run_until_tick(IDLE, n);
    check("first_tick_latency", n, 16);

    // Four IDLE ticks in total, last update visible one cycle after tick
    repeat (3 * PERIOD + 1) cycle(1'b0, IDLE);
    check("idle4_fome", int'(fome), 196);
    check("idle4_sono", int'(sono), 198);
    check("idle4_felicidade", int'(felicidade), 199);

    // Feeding saturates fome at 255
    repeat (10 * PERIOD) cycle(1'b0, COMENDO);
    check("comendo_sat", int'(fome), 255);

    // Starve: fome floors at 0, alerta follows fome<32 with one cycle lag
    seen_low = 0;
    n = 0;
    while (fome != 8'd0 && n < 5000) begin
      cycle(1'b0, IDLE);
      n++;
      if (!seen_low && fome < 8'd32) begin
        seen_low = 1;
        check("alerta_not_yet", int'(alerta), 0);
        cycle(1'b0, IDLE);
        n++;
        check("alerta_after_low", int'(alerta), 1);
      end
    end
    check("fome_reached_zero", int'(fome), 0);
    repeat (3 * PERIOD) cycle(1'b0, IDLE);
    check("fome_floor", int'(fome), 0);

    // MORTO freezes attributes for 10 ticks
    snap_f = m_fome; snap_h = m_fel; snap_s = m_sono;
    repeat (10 * PERIOD) cycle(1'b0, MORTO);
    check("morto_fome", int'(fome), snap_f);
    check("morto_felicidade", int'(felicidade), snap_h);
    check("morto_sono", int'(sono), snap_s);

    // INTRO reloads next cycle and holds the prescaler
    cycle(1'b0, INTRO);
    check("intro_fome", int'(fome), 200);
    check("intro_felicidade", int'(felicidade), 200);
    check("intro_sono", int'(sono), 200);
    repeat (2 * PERIOD) cycle(1'b0, INTRO);
    run_until_tick(IDLE, n);
    check("tick_after_intro", n, 16);

    // Reset during a DANDO_AULA tick cycle wins over the update
    run_until_tick(DANDO_AULA, n);
    check("aula_tick_seen", int'(tick), 1);
    cycle(1'b1, DANDO_AULA);
    check("rst_in_tick_fome", int'(fome), 200);
    check("rst_in_tick_felicidade", int'(felicidade), 200);
    check("rst_in_tick_sono", int'(sono), 200);
    check("rst_in_tick_tick", int'(tick), 0);

    // Random activity changes, including mid-interval changes and bad codes
    n = 0;
    while (n < 2500) begin
      e = pool[$urandom_range(7, 0)];
      if (e == INTRO && $urandom_range(3, 0) != 0) e = IDLE;
      hold = $urandom_range(40, 1);
      repeat (hold) begin
        cycle(($urandom_range(299, 0) == 0), e);
        n++;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
